// File: rtl/pwm_shadow_loader_pkg.sv
// Shared types and constants for the PWM shadow/active register loader.
// Counter width defaults to 16 bits unless the build defines it.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package pwm_shadow_loader_pkg;

    localparam int unsigned PWM_CW = `PWMCOUNT_WIDTH;

    localparam logic [2:0] ADDR_PERIOD = 3'd7;

    typedef enum logic {
        IDLE,
        ARMED
    } shadow_state_t;

    typedef logic [3:0] decim_t;

    localparam decim_t DECIM_MAX = 4'hF;

    // Event counter saturates instead of wrapping so a stuck decim cannot alias.
    function automatic decim_t decim_inc(input decim_t c);
        return (c == DECIM_MAX) ? c : c + 4'd1;
    endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// One shadow/active register pair: software writes the shadow,
// the loader copies it into the active copy on a qualified event.
module pwm_shadow_reg #(
    parameter int unsigned     CW  = 16,
    parameter logic [CW-1:0]   RST = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          load,
    input  logic [CW-1:0] data,
    output logic [CW-1:0] active
);

    logic [CW-1:0] shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= RST;
        end else if (we) begin
            shadow <= data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= RST;
        end else if (load) begin
            active <= shadow;
        end
    end

endmodule

// File: rtl/pwm_shadow_loader.sv
// Atomic shadow-to-active transfer of a PWM channel group's compares
// and period, gated by decimated mask events from the carrier.
module pwm_shadow_loader
    import pwm_shadow_loader_pkg::*;
#(
    parameter int unsigned CW         = PWM_CW,
    parameter int unsigned NCMP       = 4,
    parameter logic [15:0] PERIOD_RST = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_addr,
    input  logic [CW-1:0]      wr_data,
    input  logic               commit,
    input  logic [3:0]         decim,
    input  logic               maskevent,
    output logic [CW-1:0]      period_act,
    output logic [NCMP*CW-1:0] cmp_act,
    output logic               pending,
    output logic               update_pulse,
    output logic               overrun,
    input  logic               overrun_clr
);

    localparam logic [CW-1:0] PER_RST = CW'(PERIOD_RST);

    shadow_state_t state;
    decim_t        ev_cnt;

    logic          wr_fire;
    logic          armed;
    logic          qualify;
    logic          ovr_set;
    logic          per_we;
    logic [NCMP-1:0] cmp_we;

    assign armed    = (state == ARMED);
    assign wr_ready = (state == IDLE);
    assign pending  = armed;
    assign wr_fire  = wr_valid & wr_ready;

    // >= rather than == so lowering decim mid-wait releases on the next event.
    assign qualify = armed & maskevent & (ev_cnt >= decim);
    assign ovr_set = armed & commit;

    assign per_we = wr_fire & (wr_addr == ADDR_PERIOD);

    for (genvar i = 0; i < NCMP; i++) begin : g_cmp
        assign cmp_we[i] = wr_fire & (wr_addr == 3'(i));

        pwm_shadow_reg #(
            .CW  (CW),
            .RST ('0)
        ) u_cmp (
            .clk    (clk),
            .reset  (reset),
            .we     (cmp_we[i]),
            .load   (qualify),
            .data   (wr_data),
            .active (cmp_act[i*CW +: CW])
        );
    end

    pwm_shadow_reg #(
        .CW  (CW),
        .RST (PER_RST)
    ) u_period (
        .clk    (clk),
        .reset  (reset),
        .we     (per_we),
        .load   (qualify),
        .data   (wr_data),
        .active (period_act)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ev_cnt       <= '0;
            update_pulse <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            overrun      <= ovr_set | (overrun & ~overrun_clr);
            unique case (1'b1)
                (state == IDLE): begin
                    if (commit) begin
                        state  <= ARMED;
                        ev_cnt <= '0;
                    end
                end
                (state == ARMED): begin
                    if (qualify) begin
                        state        <= IDLE;
                        ev_cnt       <= '0;
                        update_pulse <= 1'b1;
                    end else if (maskevent) begin
                        ev_cnt <= decim_inc(ev_cnt);
                    end
                end
                default: begin
                    state  <= IDLE;
                    ev_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_shadow_loader.sv
// Scoreboard bench for pwm_shadow_loader: committed shadow snapshots are
// queued and compared against the active outputs on each update pulse.
module tb_pwm_shadow_loader;

    localparam int CW   = 16;
    localparam int NCMP = 4;

    typedef struct {
        logic [15:0] per;
        logic [63:0] cmp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit;
    logic [3:0]  decim;
    logic        maskevent;
    logic [15:0] period_act;
    logic [63:0] cmp_act;
    logic        pending;
    logic        update_pulse;
    logic        overrun;
    logic        overrun_clr;

    int total = 0;
    int bad   = 0;
    int n_upd = 0;

    exp_t        sbq[$];
    logic [63:0] sh_cmp  = '0;
    logic [15:0] sh_per  = 16'hFFFF;
    logic [63:0] act_cmp = '0;
    logic [15:0] act_per = 16'hFFFF;
    logic        armed   = 1'b0;

    pwm_shadow_loader #(
        .CW         (CW),
        .NCMP       (NCMP),
        .PERIOD_RST (16'hFFFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit       (commit),
        .decim        (decim),
        .maskevent    (maskevent),
        .period_act   (period_act),
        .cmp_act      (cmp_act),
        .pending      (pending),
        .update_pulse (update_pulse),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && update_pulse) begin
            n_upd++;
            if (sbq.size() == 0) begin
                chk("sb_underflow", 64'(sbq.size()), 64'd1);
            end else begin
                e = sbq.pop_front();
                chk("upd_period", 64'(period_act), 64'(e.per));
                chk("upd_cmp", cmp_act, e.cmp);
                act_per = e.per;
                act_cmp = e.cmp;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && n < 100) begin
            tick();
            n++;
        end
        chk("wr_ready_to", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        if (a < 3'(NCMP)) sh_cmp[a*16 +: 16] = d;
        else if (a == 3'd7) sh_per = d;
    endtask

    task automatic push_snap;
        exp_t e;
        e.per = sh_per;
        e.cmp = sh_cmp;
        sbq.push_back(e);
    endtask

    task automatic do_commit;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        if (!armed) begin
            push_snap();
            armed = 1'b1;
        end
    endtask

    task automatic mev;
        maskevent = 1'b1;
        tick();
        maskevent = 1'b0;
    endtask

    initial begin
        int base;
        int e;
        reset       = 1'b1;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        commit      = 1'b0;
        decim       = 4'd0;
        maskevent   = 1'b0;
        overrun_clr = 1'b0;
        tick();
        tick();
        chk("rst_per", 64'(period_act), 64'hFFFF);
        chk("rst_cmp", cmp_act, 64'd0);
        chk("rst_pend", 64'(pending), 64'd0);
        chk("rst_upd", 64'(update_pulse), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_rdy", 64'(wr_ready), 64'd1);
        reset = 1'b0;
        tick();

        // basic transfer with decim=0
        wr(3'd0, 16'd100);
        wr(3'd1, 16'd200);
        wr(3'd7, 16'd1000);
        do_commit();
        chk("t1_pend", 64'(pending), 64'd1);
        chk("t1_rdy", 64'(wr_ready), 64'd0);
        repeat (5) tick();
        chk("t1_hold_cmp", cmp_act, act_cmp);
        chk("t1_hold_per", 64'(period_act), 64'(act_per));
        mev();
        armed = 1'b0;
        chk("t1_upd_hi", 64'(update_pulse), 64'd1);
        chk("t1_pend_lo", 64'(pending), 64'd0);
        chk("t1_rdy_hi", 64'(wr_ready), 64'd1);
        tick();
        chk("t1_upd_1cyc", 64'(update_pulse), 64'd0);
        chk("t1_n_upd", 64'(n_upd), 64'd1);

        // decimation by 2, plus a discarded write to an unused address
        wr(3'd0, 16'd11);
        wr(3'd3, 16'd33);
        wr(3'd5, 16'd1234);
        wr(3'd7, 16'd500);
        decim = 4'd2;
        do_commit();
        base = n_upd;
        for (int k = 1; k <= 3; k++) begin
            repeat (10) begin
                tick();
                chk("t2_pend", 64'(pending), 64'd1);
            end
            mev();
            settle();
            if (k < 3) begin
                chk("t2_no_upd", 64'(n_upd), 64'(base));
                chk("t2_hold", cmp_act, act_cmp);
            end
        end
        armed = 1'b0;
        chk("t2_upd", 64'(n_upd), 64'(base + 1));
        chk("t2_pend_lo", 64'(pending), 64'd0);

        // write held off while armed
        decim = 4'd0;
        wr(3'd1, 16'd7);
        do_commit();
        wr_valid = 1'b1;
        wr_addr  = 3'd0;
        wr_data  = 16'd55;
        repeat (3) begin
            tick();
            chk("t3_rdy_lo", 64'(wr_ready), 64'd0);
        end
        mev();
        armed = 1'b0;
        chk("t3_rdy_back", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        sh_cmp[15:0] = 16'd55;
        settle();
        chk("t3_act_old", 64'(cmp_act[15:0]), 64'(act_cmp[15:0]));
        do_commit();
        mev();
        armed = 1'b0;
        settle();
        chk("t3_act_new", 64'(cmp_act[15:0]), 64'd55);

        // overrun behaviour
        do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t4_ovr_set", 64'(overrun), 64'd1);
        repeat (3) tick();
        chk("t4_ovr_sticky", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t4_ovr_clr", 64'(overrun), 64'd0);
        commit = 1'b1;
        overrun_clr = 1'b1;
        tick();
        commit = 1'b0;
        overrun_clr = 1'b0;
        chk("t4_set_wins", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t4_ovr_clr2", 64'(overrun), 64'd0);
        base = n_upd;
        commit = 1'b1;
        maskevent = 1'b1;
        tick();
        commit = 1'b0;
        maskevent = 1'b0;
        armed = 1'b0;
        chk("t4_cm_upd", 64'(update_pulse), 64'd1);
        chk("t4_cm_ovr", 64'(overrun), 64'd1);
        chk("t4_cm_idle", 64'(pending), 64'd0);
        tick();
        chk("t4_no_rearm", 64'(pending), 64'd0);
        chk("t4_cm_n", 64'(n_upd), 64'(base + 1));
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;

        // maskevent constantly high, decim=3
        wr(3'd2, 16'd9);
        decim = 4'd3;
        maskevent = 1'b1;
        base = n_upd;
        repeat (3) tick();
        settle();
        chk("t5_idle_ign", 64'(n_upd), 64'(base));
        chk("t5_idle_act", cmp_act, act_cmp);
        commit = 1'b1;
        push_snap();
        tick();
        commit = 1'b0;
        e = 0;
        while (e < 20) begin
            tick();
            e++;
            if (update_pulse) break;
        end
        chk("t5_latency", 64'(e), 64'd4);
        maskevent = 1'b0;
        settle();

        // reset while armed discards the shadow
        decim = 4'd0;
        wr(3'd2, 16'd77);
        do_commit();
        reset = 1'b1;
        #1;
        sbq.delete();
        sh_cmp  = '0;
        sh_per  = 16'hFFFF;
        act_cmp = '0;
        act_per = 16'hFFFF;
        armed   = 1'b0;
        chk("t6_cmp2", 64'(cmp_act[47:32]), 64'd0);
        chk("t6_per", 64'(period_act), 64'hFFFF);
        chk("t6_pend", 64'(pending), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        base = n_upd;
        mev();
        repeat (3) tick();
        settle();
        chk("t6_no_upd", 64'(n_upd), 64'(base));
        chk("t6_cmp", cmp_act, act_cmp);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_shadow_loader.md
Name: pwm_shadow_loader

Overview:
Receiver-side consumer of the mask event produced by the carrier mask logic. Software writes new compare values and a new period into shadow registers, then commits them. The block transfers all shadow values into the active registers atomically on a qualified mask event, so the carrier and comparators never see a half-updated set. It sits between the register interface and the carrier/comparator datapath of each PWM channel group.

Parameters:
CW, `PWMCOUNT_WIDTH, width of the counter, compare and period values
NCMP, 4, number of compare registers in the group (range 1..7)
PERIOD_RST, 16'hFFFF, reset value of the active and shadow period (truncated to CW)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
wr_valid  in  1  shadow write request
wr_ready  out  1  shadow write accepted when wr_valid & wr_ready
wr_addr  in  3  0..NCMP-1 selects a compare shadow; 7 selects the period shadow
wr_data  in  CW  shadow write data
commit  in  1  single-cycle pulse: the shadow set is complete, arm the transfer
decim  in  4  number of mask events to skip before transfer (0 = first event)
maskevent  in  1  registered mask event from the carrier mask logic
period_act  out  CW  active period
cmp_act  out  NCMP*CW  active compares, packed; compare i is at [i*CW +: CW]
pending  out  1  high while armed and waiting for a qualified event
update_pulse  out  1  one-cycle pulse in the cycle after the transfer
overrun  out  1  sticky: commit arrived while already armed
overrun_clr  in  1  clears overrun

Behaviour:
- Reset values:
  - active and shadow compares = 0; active and shadow period = PERIOD_RST
  - pending = 0, update_pulse = 0, overrun = 0
  - state = IDLE, event counter = 0
- States:
  - IDLE: shadow open; wr_ready = 1.
  - ARMED: shadow locked; wr_ready = 0; pending = 1.
- IDLE -> ARMED on commit. Event counter cleared to 0 on entry.
- A write and a commit in the same IDLE cycle: the write is captured, then the state arms. The committed set includes that write.
- Writes to addresses NCMP..6 are accepted (handshake completes) and discarded.
- In ARMED, each maskevent cycle is a candidate:
  - If counter == decim, it is a qualified event. At that clock edge, all active registers load from shadow in the same edge, and the state returns to IDLE.
  - Otherwise counter increments (4-bit, saturating at 15).
- decim is sampled live each cycle. If decim is lowered below the current count, the next maskevent qualifies (compare uses counter >= decim).
- Latency:
  - Active registers change at the edge that samples a qualified maskevent.
  - update_pulse is high the following cycle.
  - wr_ready returns to 1 that same following cycle.
- maskevent while IDLE: ignored. Active registers are unchanged and the counter stays 0.
- commit while ARMED: ignored for arming and sets overrun.
  - commit together with a qualified maskevent: the transfer happens, the state goes to IDLE, and overrun is set. The commit does not re-arm.
- If overrun set and overrun_clr occur in the same cycle, set wins.
- With NO_MASK upstream, maskevent is constantly high. The transfer then happens exactly decim+1 cycles after commit (on the (decim+1)-th maskevent cycle in ARMED).
- Reset asserted mid-ARMED: everything returns to reset values immediately. The shadow is discarded.
- No arithmetic on data: shadow and active values are plain CW-bit copies.

Decomposition:
- In PKG_pwm:
  - a typedef enum {IDLE, ARMED} _shadow_state
  - localparam ADDR_PERIOD = 3'd7
  - a typedef for the 4-bit decimation count
- One natural sub-module: pwm_shadow_reg (one CW-bit shadow/active register pair with write enable and load enable), instantiated NCMP+1 times.
- The state machine, event counter and overrun logic stay in the top module.

Test Plan:
- Reset, then write cmp0=100, cmp1=200, period=1000, then commit; decim=0 and maskevent pulses 5 cycles later -> cmp_act unchanged until that edge, then cmp0=100, cmp1=200, period_act=1000; update_pulse high for exactly 1 cycle; pending falls.
- decim=2, commit, then 3 maskevent pulses spaced 10 cycles apart -> no change after pulses 1 and 2; transfer on pulse 3; pending high the entire interval.
- Armed, with wr_valid held high carrying cmp0=55 -> wr_ready=0 and no handshake; after the transfer, wr_ready=1, the write completes into the shadow, and cmp_act0 still holds the old value.
- Second commit while armed -> overrun=1 and stays 1; overrun_clr pulse -> 0; overrun_clr in the same cycle as a new overrun -> stays 1.
- maskevent held high (NO_MASK), decim=3, commit at cycle t -> update_pulse at cycle t+5 (transfer edge t+4).
- Reset asserted for 1 cycle while armed after writing cmp2=77 -> cmp_act2=0, period_act=PERIOD_RST, pending=0; a subsequent maskevent causes no transfer.
